inst_prefetch_buffer: RTL and testbench

Instruction prefetch queue between the core's instruction-fetch port and a pipelined, in-order instruction memory with variable latency. It runs ahead of the core with sequential word fetches and buffers up to DEPTH returned words. When the requested address matches the queue head, it answers the core in the same cycle. On a non-sequential fetch (branch, jump or flush target) it discards stale data and restarts the stream.

---
 rtl/inst_prefetch_buffer_pkg.sv | 15 +
 rtl/inst_prefetch_buffer_sync_fifo.sv | 49 ++++
 rtl/inst_prefetch_buffer.sv | 134 +++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package inst_prefetch_buffer_pkg;

    typedef enum logic {IDLE, STREAM} fetchStateType;

    localparam int INST_WORD_BYTES = 4;

    typedef logic [31:0] dataBus_t;

    // Sequential word successor; wraps modulo 2^32.
    function automatic dataBus_t next_word(input dataBus_t addr);
        return addr + dataBus_t'(INST_WORD_BYTES);
    endfunction

endpackage

// File: rtl/inst_prefetch_buffer_sync_fifo.sv
// DEPTH x 32 synchronous FIFO with flush; pointers wrap through their log2(DEPTH) width.
module sync_fifo
    import inst_prefetch_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  dataBus_t      push_data,
    input  logic          pop,
    output dataBus_t      head_data,
    output logic [CW-1:0] count
);

    dataBus_t      mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // NOTE: the storage array has no reset; count gates every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue: streams sequential fetches ahead of the core and
// answers hits on the queue head in the same cycle; redirects restart the stream.
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_core_rd_en,
    input  dataBus_t   i_core_addr,
    output logic       o_core_ready,
    output dataBus_t   o_core_data,
    output logic       o_mem_req,
    output dataBus_t   o_mem_addr,
    input  logic       i_mem_gnt,
    input  logic       i_mem_rvalid,
    input  dataBus_t   i_mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;

    fetchStateType state;
    fetchStateType state_next;
    dataBus_t      head_addr;
    dataBus_t      head_addr_next;
    dataBus_t      pf_addr;
    dataBus_t      pf_addr_next;
    cnt_t          outstanding;
    cnt_t          outstanding_next;
    cnt_t          discard;
    cnt_t          discard_next;
    cnt_t          count;
    cnt_t          count_next;
    logic          mem_req;
    logic          mem_req_next;
    logic [CW:0]   credit_use;

    dataBus_t      core_addr;
    dataBus_t      fifo_head;
    logic          req;
    logic          hit;
    logic          redirect;
    logic          gnt;
    logic          rsp;
    logic          push;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data (i_mem_rdata),
        .pop       (hit),
        .head_data (fifo_head),
        .count     (count)
    );

    // NOTE: every always_comb output is given a default first, so no latch can be inferred.
    always_comb begin
        req       = |i_core_rd_en;
        core_addr = i_core_addr & ~dataBus_t'(INST_WORD_BYTES - 1);
        hit       = 1'b0;
        redirect  = 1'b0;
        if (req) begin
            if (state == IDLE || core_addr != head_addr) begin
                redirect = 1'b1;
            end else if (count != '0) begin
                hit = 1'b1;
            end
        end
        gnt  = mem_req && i_mem_gnt;
        // A response with nothing outstanding belongs to a stream killed by reset.
        rsp  = i_mem_rvalid && (outstanding != '0);
        push = rsp && (discard == '0) && !redirect;
    end

    // NOTE: next-state values use blocking assigns here; the registers below update with <= only.
    always_comb begin
        state_next       = state;
        head_addr_next   = head_addr;
        pf_addr_next     = gnt ? next_word(pf_addr) : pf_addr;
        outstanding_next = outstanding + cnt_t'(gnt) - cnt_t'(rsp);
        discard_next     = discard;
        count_next       = count + cnt_t'(push) - cnt_t'(hit);

        if (redirect) begin
            state_next     = STREAM;
            head_addr_next = core_addr;
            pf_addr_next   = core_addr;
            count_next     = '0;
            // Everything still in flight after this cycle belongs to the old stream.
            discard_next   = outstanding_next;
        end else begin
            if (hit) begin
                head_addr_next = next_word(head_addr);
            end
            if (rsp && discard != '0) begin
                discard_next = discard - cnt_t'(1);
            end
        end

        credit_use   = {1'b0, count_next} + {1'b0, outstanding_next};
        mem_req_next = (state_next == STREAM) && (credit_use < CREDITS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            head_addr   <= '0;
            pf_addr     <= '0;
            outstanding <= '0;
            discard     <= '0;
            mem_req     <= 1'b0;
        end else begin
            state       <= state_next;
            head_addr   <= head_addr_next;
            pf_addr     <= pf_addr_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            mem_req     <= mem_req_next;
        end
    end

    assign o_core_ready = hit;
    assign o_core_data  = hit ? fifo_head : '0;
    assign o_mem_req    = mem_req;
    assign o_mem_addr   = pf_addr;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Scoreboard bench for inst_prefetch_buffer with an in-order variable-latency memory model.
module tb_inst_prefetch_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } gnt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  core_en;
    logic [31:0] core_addr;
    logic        core_ready;
    logic [31:0] core_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int   cyc = 0;
    int   lat = 2;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    gnt_t pend[$];
    gnt_t grant_log[$];
    int   ready_log[$];

    inst_prefetch_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_core_rd_en (core_en),
        .i_core_addr  (core_addr),
        .o_core_ready (core_ready),
        .o_core_data  (core_data),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory: grants every request, answers in order after lat cycles.
    initial begin
        gnt_t p;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (pend.size() > 0 && pend[0].cyc <= cyc) begin
                p          = pend.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(p.addr);
            end
            if (mem_req && mem_gnt) begin
                pend.push_back('{mem_addr, cyc + lat});
                grant_log.push_back('{mem_addr, cyc});
            end
        end
    end

    // Monitor: every delivered word must be the next one the core asked for.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && core_ready) begin
                ready_log.push_back(cyc);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ready: data 0x%08h delivered, no fetch expected", core_data);
                end else begin
                    e = sb_q.pop_front();
                    check("core_data", core_data, e.data);
                end
            end
        end
    end

    // Called at posedge+1; holds the address until the word is delivered.
    task automatic fetch(input logic [31:0] a);
        int n;
        sb_q.push_back('{a, mem_word(a)});
        core_en   = 4'hF;
        core_addr = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (core_ready) break;
            n++;
            if (n > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL fetch_timeout: addr 0x%08h got no ready in %0d cycles, expected ready", a, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        core_en = 4'h0;
    endtask

    task automatic idle(input int n);
        core_en = 4'h0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        core_en = 4'h0;
        while (pend.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", pend.size(), 0);
    endtask

    task automatic do_reset();
        core_en = 4'h0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Counts cycles with o_mem_req / o_core_ready high over a window (core idle).
    task automatic sample_quiet(input int n, output int reqs, output int readies);
        reqs    = 0;
        readies = 0;
        repeat (n) begin
            @(negedge clk);
            if (mem_req)    reqs++;
            if (core_ready) readies++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int gaps;
        int reqs;
        int readies;

        rst       = 1'b1;
        core_en   = 4'h0;
        core_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_core_ready", core_ready, 0);
        check("reset_core_data", core_data, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_mem_addr", mem_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First fetch after reset, latency 2.
        lat = 2;
        grant_log.delete();
        ready_log.delete();
        t0 = cyc;
        fetch(32'h100);
        check("first_grant_count_ge4", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            check("first_req_cycle", grant_log[0].cyc, t0 + 1);
            for (int i = 0; i < 4; i++) begin
                check("issue_addr", grant_log[i].addr, 32'h100 + 32'(4 * i));
            end
        end
        check("first_ready_cycle", ready_log.size() > 0 ? ready_log[0] : -1, t0 + 4);

        // Core idle until the queue fills; no requests while full.
        idle(4);
        sample_quiet(8, reqs, readies);
        check("full_no_req", reqs, 0);
        ready_log.delete();
        t0 = cyc;
        fetch(32'h104);
        check("hit_zero_latency", ready_log.size() > 0 ? ready_log[0] : -1, t0);
        check("req_after_pop", mem_req, 1);
        check("req_addr_after_pop", mem_addr, 32'h114);

        // Sequential stream with single-cycle memory.
        drain();
        do_reset();
        lat = 1;
        ready_log.delete();
        for (int i = 0; i < 16; i++) begin
            fetch(32'h100 + 32'(4 * i));
        end
        check("stream_ready_count", ready_log.size(), 16);
        gaps = 0;
        for (int i = 1; i < ready_log.size(); i++) begin
            if (ready_log[i] != ready_log[i-1] + 1) gaps++;
        end
        check("stream_gapless", gaps, 0);

        // Redirect with stale responses still in flight.
        drain();
        do_reset();
        lat = 4;
        fetch(32'h100);
        fetch(32'h800);
        fetch(32'h804);
        fetch(32'h808);

        // Redirect across the top of the address space.
        fetch(32'hFFFF_FFF8);
        fetch(32'hFFFF_FFFC);
        fetch(32'h0000_0000);
        fetch(32'h0000_0004);

        // Reset with two responses in flight that return after reset.
        drain();
        do_reset();
        lat = 3;
        core_en   = 4'hF;
        core_addr = 32'h200;
        @(posedge clk);
        #1;
        core_en = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sample_quiet(6, reqs, readies);
        check("post_reset_no_req", reqs, 0);
        check("post_reset_no_ready", readies, 0);
        check("post_reset_stale_drained", pend.size(), 0);
        lat = 2;
        grant_log.delete();
        ready_log.delete();
        t0 = cyc;
        fetch(32'h300);
        check("rst_first_grant_seen", grant_log.size() > 0, 1);
        if (grant_log.size() > 0) begin
            check("rst_first_req_cycle", grant_log[0].cyc, t0 + 1);
            check("rst_first_req_addr", grant_log[0].addr, 32'h300);
        end
        check("rst_first_ready_cycle", ready_log.size() > 0 ? ready_log[0] : -1, t0 + 4);
        fetch(32'h304);

        drain();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
